sr_flag_arbiter: RTL
====================

// Module: sr_flag_arbiter
// PURPOSE
//   Shares one bank of NFLAG SR-style flag registers among NREQ requesters.
//   Each requester issues {s,r} commands against a flag index over a valid/ready
//   handshake; a round-robin arbiter accepts at most one command per cycle and
//   applies it to the bank. It also counts illegal (s=r=1) and out-of-range commands.
// PARAMETERS
//   NREQ    4  number of requesters (2..8)
//   NFLAG   8  number of SR flag registers in the bank
//   FIDX_W  3  flag index width; 2**FIDX_W >= NFLAG
//   CNT_W   8  width of error counter
// PORTS
//   clk          in   1             clock, all logic on posedge
//   rst          in   1             synchronous reset, active-high
//   req_valid    in   NREQ          per-requester command valid
//   req_ready    out  NREQ          per-requester accept (one-hot or zero)
//   req_op       in   2*NREQ        {s,r} per requester, requester i at [2i+1:2i]
//   req_idx      in   FIDX_W*NREQ   flag index per requester, i at [FIDX_W*i +: FIDX_W]
//   flags        out  NFLAG         current flag bank (registered)
//   grant_valid  out  1             registered: a command was accepted last cycle
//   grant_id     out  clog2(NREQ)   registered: requester accepted last cycle
//   err_sticky   out  1             set by any illegal/out-of-range command, cleared by rst only
//   err_cnt      out  CNT_W         saturating count of illegal/out-of-range commands
// BEHAVIOUR
//   - Reset (rst=1 at posedge): flags=0, ptr=0, grant_valid=0, grant_id=0,
//     err_sticky=0, err_cnt=0. req_ready forced all-zero while rst=1 (combinational).
//   - Arbitration (combinational): winner = first i with req_valid[i]=1 searching
//     ptr, ptr+1, ... mod NREQ. req_ready[winner]=1, all others 0; no valid -> all 0.
//     req_ready depends on req_valid; requesters must not gate valid on ready.
//   - Transfer = req_valid[i] & req_ready[i]. Requester holds op/idx stable until transfer.
//   - Pointer: on transfer ptr <= (winner+1) mod NREQ; no transfer -> ptr holds.
//     Guarantees each continuously-valid requester is served within NREQ cycles.
//   - Command effect on flags[idx] at the transfer edge (visible next cycle, latency 1):
//       00 hold; 01 clear to 0; 10 set to 1; 11 see CONFIGURATION.
//   - idx >= NFLAG: command accepted (ready asserted normally), no flag changes,
//     counted as error. Error on same cycle as 11-illegal counts once.
//   - err_cnt saturates at 2**CNT_W-1; err_sticky set on same edge as the increment.
//   - grant_valid/grant_id: registered copy of transfer/winner each cycle; grant_id
//     holds its last value when grant_valid=0.
//   - Only one command per cycle, so no write collisions within the bank.
//   - Reset mid-operation: rst overrides pending transfer; that command is lost and
//     requester must retry (it sees ready=0 during rst).
// CONFIGURATION
//   SR_ARB_TOGGLE_EN defined: op 11 toggles flags[idx] (JK behaviour), not an error.
//   SR_ARB_TOGGLE_EN undefined: op 11 is illegal -> flag unchanged, err_sticky=1,
//     err_cnt increments (saturating).
// TESTING
//   1. rst=1 two cycles with all req_valid=1 -> req_ready=0, flags=0, err_cnt=0 after.
//   2. Req0 op=10 idx=3 alone -> ready[0]=1 same cycle; next cycle flags=8'h08,
//      grant_valid=1, grant_id=0; then op=01 idx=3 -> flags=8'h00.
//   3. All 4 valid continuously, ptr=0 -> grants 0,1,2,3,0 on successive cycles;
//      drop req1 -> order 0,2,3,0.
//   4. Op=11 idx=5 from flags=0: toggle build -> flags=8'h20, err_cnt=0;
//      default build -> flags=0, err_sticky=1, err_cnt=1.
//   5. idx=7 (legal) vs idx=9 with NFLAG=8,FIDX_W=4 -> 9 accepted, flags unchanged,
//      err_cnt+1; drive 300 errors with CNT_W=8 -> err_cnt stays 255.
//   6. Assert rst on the cycle req2 is granted -> flags unchanged by req2, ptr=0,
//      next cycle req0 (if valid) wins.

Source files
------------

// File: rtl/sr_flag_arbiter_if.sv
// Requester-side command bus for sr_flag_arbiter: one valid/ready/op/idx lane per requester.
// Requesters drive the master modport; the arbiter consumes the slave modport.
interface sr_flag_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int FIDX_W = 3
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [2*NREQ-1:0]      req_op;
  logic [FIDX_W*NREQ-1:0] req_idx;

  modport master (output req_valid, output req_op, output req_idx, input req_ready);
  modport slave  (input req_valid, input req_op, input req_idx, output req_ready);
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin shared SR flag bank with error counting for illegal/out-of-range commands.
// Optional macro SR_ARB_TOGGLE_EN turns op 11 into a toggle (JK style) instead of an error.
module sr_flag_arbiter #(
  parameter int NREQ   = 4,
  parameter int NFLAG  = 8,
  parameter int FIDX_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  sr_flag_arbiter_if.slave                        req,
  output logic [NFLAG-1:0]                        flags,
  output logic                                    grant_valid,
  output logic [(NREQ > 1 ? $clog2(NREQ) : 1)-1:0] grant_id,
  output logic                                    err_sticky,
  output logic [CNT_W-1:0]                        err_cnt
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [FIDX_W:0] NFLAG_V = NFLAG[FIDX_W:0];

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              transfer;
  logic [1:0]        sel_op;
  logic [FIDX_W-1:0] sel_idx;
  logic              in_range;
  logic              err_event;
  logic [NFLAG-1:0]  flags_nxt;

  // Search starts at ptr and wraps, so the most recently served requester goes last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req.req_valid[(int'(ptr) + k) % NREQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    req.req_ready = '0;
    if (found && !rst) req.req_ready[winner] = 1'b1;
  end

  assign transfer = found & ~rst;
  assign sel_op   = req.req_op[2*winner +: 2];
  assign sel_idx  = req.req_idx[FIDX_W*winner +: FIDX_W];
  assign in_range = ({1'b0, sel_idx} < NFLAG_V);

  // Out-of-range and illegal op in the same command still count as one error.
  always_comb begin
    flags_nxt = flags;
    err_event = 1'b0;
    if (transfer) begin
      if (!in_range) begin
        err_event = 1'b1;
      end else begin
        case (sel_op)
          2'b01:   flags_nxt[sel_idx] = 1'b0;
          2'b10:   flags_nxt[sel_idx] = 1'b1;
`ifdef SR_ARB_TOGGLE_EN
          2'b11:   flags_nxt[sel_idx] = ~flags[sel_idx];
`else
          2'b11:   err_event = 1'b1;
`endif
          default: flags_nxt = flags;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags       <= '0;
      ptr         <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      err_sticky  <= 1'b0;
      err_cnt     <= '0;
    end else begin
      flags       <= flags_nxt;
      grant_valid <= transfer;
      if (transfer) begin
        grant_id <= winner;
        ptr      <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);
      end
      if (err_event) begin
        err_sticky <= 1'b1;
        if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule
